watchdog_kicker: RTL and testbench
==================================

// Module: watchdog_kicker
// PURPOSE
//   Sends periodic kicks to the windowed watchdog. Each kick lands inside the watchdog's open window [THRESHOLD, COUNT).
//   A kick is sent only after every monitored task has shown liveness since the previous kick.
//   If a task stays silent, the kick is withheld so the watchdog times out. Reports which tasks were missing.
// PARAMETERS
//   LENGTH     5   cycle-counter width; must hold COUNT
//   COUNT      20  watchdog maximum count; must match the paired watchdog
//   THRESHOLD  10  watchdog window open; must match the paired watchdog
//   KICK_AT    15  nominal kick point; THRESHOLD <= KICK_AT < LATE_LIMIT required
//   GUARD      2   margin below COUNT; LATE_LIMIT = COUNT-GUARD is the last kick point
//   N_TASKS    4   number of alive inputs
//   KCNT_W     8   width of kick_count
// PORTS
//   clk         in   1        single clock; all logic posedge
//   reset_n     in   1        asynchronous, active-low reset
//   enable      in   1        high = kicking active; low = return to IDLE
//   alive       in   N_TASKS  per-task liveness pulse, sampled each cycle
//   wd_timeout  in   1        timeout output of the paired watchdog
//   kick        out  1        one-cycle kick pulse to the watchdog
//   fault       out  1        sticky: kick withheld or watchdog timed out
//   missing     out  N_TASKS  tasks not seen when fault was set; sticky
//   kick_count  out  KCNT_W   kicks issued since IDLE; saturates at all-ones
// BEHAVIOUR
//   Reset (async, reset_n=0):
//     - kick=0, fault=0, missing=0, kick_count=0
//     - state=IDLE, cnt=0, seen=0
//   All outputs are registered.
//   States: IDLE, WAIT, LATE, FAULT.
//   IDLE:
//     - cnt=0, seen=0, kick=0, fault=0, missing=0, kick_count=0
//     - enable=1 -> WAIT at next edge
//   WAIT:
//     - cnt+=1 and seen|=alive each cycle
//     - At the edge where cnt==KICK_AT:
//       - (seen|alive) all ones -> kick=1 for 1 cycle, cnt=0, seen=0, kick_count+=1 (saturating), stay in WAIT
//       - otherwise -> LATE
//   LATE:
//     - cnt+=1 and seen|=alive each cycle
//     - First edge with (seen|alive) all ones and cnt<=LATE_LIMIT -> kick as in WAIT, return to WAIT
//     - Edge with cnt==LATE_LIMIT and tasks still missing -> FAULT; missing=~(seen|alive), fault=1, no kick
//   FAULT:
//     - kick held at 0; cnt frozen; fault and missing held
//     - Exit only via enable=0 (to IDLE) or reset
//   Simultaneous events:
//     - alive in the decision cycle counts toward the current period
//     - alive in the cycle after a kick counts toward the next period
//   wd_timeout=1 in WAIT or LATE -> FAULT next edge; missing=~(seen|alive), fault=1. Has priority over a kick that edge.
//   enable=0 in any state -> IDLE next edge; a pending kick is dropped; kick never stretches.
//   Kick spacing is KICK_AT+1..LATE_LIMIT+1 cycles, which keeps each kick inside the watchdog window.
//   cnt never exceeds LATE_LIMIT, so there is no wrap.
// STRUCTURE
//   Package watchdog_pkg:
//     - state encoding localparams (IDLE/WAIT/LATE/FAULT)
//     - shared window defaults COUNT/THRESHOLD/LENGTH, used by both watchdog and kicker
//   Sub-module alive_tracker (N_TASKS):
//     - sticky seen register; inputs alive and clr
//     - outputs seen_now=seen|alive and all_seen
//   Top level holds the FSM, cnt, kick_count and the output registers.
// TESTING
//   1. reset_n=0 mid-WAIT -> all outputs 0 immediately, asynchronously; after release, state is IDLE.
//   2. enable=1, alive=4'hF every cycle -> kick pulses 16 cycles apart; kick_count 1,2,3; paired watchdog timeout stays 0.
//   3. Task 2 first pulses at cnt=17 -> no kick at 15; kick on the edge after cnt=17; back to WAIT; fault=0.
//   4. Task 1 silent -> at cnt=18: fault=1, missing=4'b0010, no kick; watchdog times out; enable=0 -> IDLE, fault=0.
//   5. wd_timeout forced high in the same cycle that all tasks arrive at cnt=15 -> FAULT, no kick.
//   6. Force kick_count to 255 -> further kicks leave it at 255; enable drop clears it to 0.

Source files
------------

// File: rtl/watchdog_pkg.sv
// Shared window defaults and kicker state encoding for the watchdog pair.
package watchdog_pkg;

    localparam int unsigned WD_LENGTH    = 5;
    localparam int unsigned WD_COUNT     = 20;
    localparam int unsigned WD_THRESHOLD = 10;

    localparam int unsigned WD_KICK_AT   = 15;
    localparam int unsigned WD_GUARD     = 2;
    localparam int unsigned WD_N_TASKS   = 4;
    localparam int unsigned WD_KCNT_W    = 8;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_WAIT  = 2'd1;
    localparam logic [STATE_W-1:0] ST_LATE  = 2'd2;
    localparam logic [STATE_W-1:0] ST_FAULT = 2'd3;

endpackage

// File: rtl/watchdog_kicker_alive_tracker.sv
// Sticky per-task liveness record for the current kick period.
module alive_tracker #(
    parameter int unsigned N_TASKS = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_TASKS-1:0] alive,
    input  logic               clr,
    output logic [N_TASKS-1:0] seen_now,
    output logic               all_seen
);

    logic [N_TASKS-1:0] seen_q;

    // Pulses in the current cycle count toward the decision taken this cycle.
    assign seen_now = seen_q | alive;
    assign all_seen = &seen_now;

    // Accumulate liveness until the period is closed by clr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen_q <= '0;
        end else if (clr) begin
            seen_q <= '0;
        end else begin
            seen_q <= seen_now;
        end
    end

endmodule

// File: rtl/watchdog_kicker.sv
// Kicks a windowed watchdog only when every monitored task has shown liveness.
module watchdog_kicker
    import watchdog_pkg::*;
#(
    parameter int unsigned LENGTH    = WD_LENGTH,
    parameter int unsigned COUNT     = WD_COUNT,
    parameter int unsigned THRESHOLD = WD_THRESHOLD,
    parameter int unsigned KICK_AT   = WD_KICK_AT,
    parameter int unsigned GUARD     = WD_GUARD,
    parameter int unsigned N_TASKS   = WD_N_TASKS,
    parameter int unsigned KCNT_W    = WD_KCNT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [N_TASKS-1:0] alive,
    input  logic               wd_timeout,
    output logic               kick,
    output logic               fault,
    output logic [N_TASKS-1:0] missing,
    output logic [KCNT_W-1:0]  kick_count
);

    localparam int unsigned LATE_LIMIT = COUNT - GUARD;
    // A kick point below the window opening would trip the watchdog early.
    localparam int unsigned KICK_PT    = (KICK_AT < THRESHOLD) ? THRESHOLD : KICK_AT;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [LENGTH-1:0]  cnt_q;
    logic [LENGTH-1:0]  cnt_d;
    logic               kick_d;
    logic               fault_d;
    logic [N_TASKS-1:0] missing_d;
    logic [KCNT_W-1:0]  kcnt_d;
    logic               clr;
    logic [N_TASKS-1:0] seen_now;
    logic               all_seen;

    logic running;
    logic at_kick;
    logic at_limit;
    logic kick_fire;
    logic fault_set;

    alive_tracker #(
        .N_TASKS (N_TASKS)
    ) u_tracker (
        .clk      (clk),
        .reset_n  (reset_n),
        .alive    (alive),
        .clr      (clr),
        .seen_now (seen_now),
        .all_seen (all_seen)
    );

    // Decision terms shared by next-state and output logic.
    always_comb begin
        running   = (state_q == ST_WAIT) || (state_q == ST_LATE);
        at_kick   = (cnt_q == LENGTH'(KICK_PT));
        at_limit  = (cnt_q == LENGTH'(LATE_LIMIT));
        kick_fire = running && !wd_timeout && all_seen &&
                    ((state_q == ST_LATE) || at_kick);
        fault_set = running && (wd_timeout ||
                    ((state_q == ST_LATE) && at_limit && !all_seen));
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; dropping enable always wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable) state_d = ST_WAIT;
            ST_WAIT: begin
                if (fault_set)                 state_d = ST_FAULT;
                else if (at_kick && !all_seen) state_d = ST_LATE;
            end
            ST_LATE: begin
                if (fault_set)      state_d = ST_FAULT;
                else if (kick_fire) state_d = ST_WAIT;
            end
            default: state_d = state_q;
        endcase
        if (!enable) state_d = ST_IDLE;
    end

    // Output and counter next values; a timeout outranks a kick on the same edge.
    always_comb begin
        cnt_d     = cnt_q;
        kick_d    = 1'b0;
        fault_d   = fault;
        missing_d = missing;
        kcnt_d    = kick_count;
        clr       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                fault_d   = 1'b0;
                missing_d = '0;
                kcnt_d    = '0;
                clr       = 1'b1;
            end
            ST_WAIT, ST_LATE: begin
                if (fault_set) begin
                    fault_d   = 1'b1;
                    missing_d = ~seen_now;
                end else if (kick_fire) begin
                    kick_d = 1'b1;
                    cnt_d  = '0;
                    clr    = 1'b1;
                    kcnt_d = (&kick_count) ? kick_count : kick_count + KCNT_W'(1);
                end else begin
                    cnt_d = cnt_q + LENGTH'(1);
                end
            end
            default: cnt_d = cnt_q;
        endcase
        if (!enable) begin
            cnt_d     = '0;
            kick_d    = 1'b0;
            fault_d   = 1'b0;
            missing_d = '0;
            kcnt_d    = '0;
            clr       = 1'b1;
        end
    end

    // Output and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            kick       <= 1'b0;
            fault      <= 1'b0;
            missing    <= '0;
            kick_count <= '0;
        end else begin
            cnt_q      <= cnt_d;
            kick       <= kick_d;
            fault      <= fault_d;
            missing    <= missing_d;
            kick_count <= kcnt_d;
        end
    end

endmodule

// File: tb/tb_watchdog_kicker.sv
// Scoreboard bench for watchdog_kicker against a period-level reference model.
module tb_watchdog_kicker;

    localparam int unsigned NT         = 4;
    localparam int unsigned KW         = 8;
    localparam int          KICK_AT    = 15;
    localparam int          LATE_LIMIT = 18;
    localparam logic [NT-1:0] ALL      = 4'hF;

    typedef struct {
        logic          kick;
        logic          fault;
        logic [NT-1:0] missing;
        logic [KW-1:0] kc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [NT-1:0] alive;
    logic          wd_timeout;
    logic          kick;
    logic          fault;
    logic [NT-1:0] missing;
    logic [KW-1:0] kick_count;

    int   tests = 0;
    int   fails = 0;
    exp_t sb_q[$];

    // Reference model: one kick period at a time.
    bit            m_active  = 1'b0;
    bit            m_faulted = 1'b0;
    int            m_elapsed = 0;
    logic [NT-1:0] m_seen    = '0;
    exp_t          m_out     = '{1'b0, 1'b0, '0, '0};

    int            mon_cyc  = 0;
    int            mon_last = -1;
    exp_t          mon_e;
    logic [NT-1:0] r_al;
    logic          r_en;
    logic          r_wt;

    watchdog_kicker dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .alive      (alive),
        .wd_timeout (wd_timeout),
        .kick       (kick),
        .fault      (fault),
        .missing    (missing),
        .kick_count (kick_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_active  = 1'b0;
        m_faulted = 1'b0;
        m_elapsed = 0;
        m_seen    = '0;
        m_out     = '{1'b0, 1'b0, '0, '0};
    endtask

    task automatic model_step(input logic en, input logic [NT-1:0] al, input logic wt);
        logic [NT-1:0] now;
        m_out.kick = 1'b0;
        if (!en) begin
            model_reset();
        end else if (!m_active) begin
            m_active  = 1'b1;
            m_elapsed = 0;
            m_seen    = '0;
        end else if (!m_faulted) begin
            now = m_seen | al;
            if (wt) begin
                m_faulted     = 1'b1;
                m_out.fault   = 1'b1;
                m_out.missing = ~now;
            end else if (m_elapsed >= KICK_AT && now == ALL) begin
                m_out.kick = 1'b1;
                if (m_out.kc != 8'hFF) m_out.kc = m_out.kc + 8'd1;
                m_elapsed  = 0;
                m_seen     = '0;
            end else if (m_elapsed == LATE_LIMIT) begin
                m_faulted     = 1'b1;
                m_out.fault   = 1'b1;
                m_out.missing = ~now;
            end else begin
                m_elapsed = m_elapsed + 1;
                m_seen    = now;
            end
        end
    endtask

    // Apply one cycle of stimulus and queue the expected registered outputs.
    task automatic drive(input logic en, input logic [NT-1:0] al, input logic wt);
        enable     = en;
        alive      = al;
        wd_timeout = wt;
        @(posedge clk);
        model_step(en, al, wt);
        sb_q.push_back(m_out);
        #1;
    endtask

    // Monitor: compare every presented output cycle and kick spacing.
    initial begin
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                tests++;
                if (kick !== mon_e.kick || fault !== mon_e.fault ||
                    missing !== mon_e.missing || kick_count !== mon_e.kc) begin
                    fails++;
                    $display("FAIL outputs cyc=%0d got kick=%b fault=%b missing=%b kc=%0d want kick=%b fault=%b missing=%b kc=%0d",
                             mon_cyc, kick, fault, missing, kick_count,
                             mon_e.kick, mon_e.fault, mon_e.missing, mon_e.kc);
                end
                if (kick_count == '0) mon_last = -1;
                if (kick === 1'b1) begin
                    if (mon_last >= 0) begin
                        tests++;
                        if (mon_cyc - mon_last < KICK_AT + 1 || mon_cyc - mon_last > LATE_LIMIT + 1) begin
                            fails++;
                            $display("FAIL kick_spacing cyc=%0d got %0d cycles want %0d..%0d",
                                     mon_cyc, mon_cyc - mon_last, KICK_AT + 1, LATE_LIMIT + 1);
                        end
                    end
                    mon_last = mon_cyc;
                end
            end
        end
    end

    // Stimulus sequence.
    initial begin
        reset_n    = 1'b0;
        enable     = 1'b0;
        alive      = '0;
        wd_timeout = 1'b0;
        #22 reset_n = 1'b1;
        @(posedge clk); #1;

        // Run into WAIT past one kick, then assert reset asynchronously.
        for (int i = 0; i < 20; i++) drive(1'b1, ALL, 1'b0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if (kick !== 1'b0 || fault !== 1'b0 || missing !== '0 || kick_count !== '0) begin
            fails++;
            $display("FAIL async_reset got kick=%b fault=%b missing=%b kc=%0d want all zero",
                     kick, fault, missing, kick_count);
        end
        model_reset();
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;

        // All tasks alive every cycle: regular kicks.
        for (int i = 0; i < 60; i++) drive(1'b1, ALL, 1'b0);

        // Align to a fresh period, then task 2 arrives late at cnt=17.
        for (int i = 0; i < 20 && !m_out.kick; i++) drive(1'b1, ALL, 1'b0);
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, (m_elapsed == 17) ? ALL : 4'b1011, 1'b0);
            if (m_out.kick) break;
        end
        for (int i = 0; i < 20; i++) drive(1'b1, ALL, 1'b0);

        // Align, then task 1 stays silent: kick withheld, fault with missing=0010.
        for (int i = 0; i < 20 && !m_out.kick; i++) drive(1'b1, ALL, 1'b0);
        for (int i = 0; i < 22; i++) drive(1'b1, 4'b1101, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, ALL, 1'b1);
        for (int i = 0; i < 2; i++) drive(1'b0, ALL, 1'b0);

        // Timeout in the same cycle that all tasks arrive at the kick point.
        drive(1'b1, '0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            if (m_elapsed == KICK_AT) begin
                drive(1'b1, ALL, 1'b1);
                break;
            end
            drive(1'b1, '0, 1'b0);
        end
        for (int i = 0; i < 3; i++) drive(1'b1, ALL, 1'b0);
        for (int i = 0; i < 2; i++) drive(1'b0, ALL, 1'b0);

        // Saturate kick_count, then clear it by dropping enable.
        for (int i = 0; i < 16 * 262; i++) drive(1'b1, ALL, 1'b0);
        for (int i = 0; i < 2; i++) drive(1'b0, ALL, 1'b0);

        // Randomized liveness, occasional timeouts and enable drops.
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < NT; b++) r_al[b] = ($urandom_range(0, 5) == 0);
            r_wt = ($urandom_range(0, 499) == 0);
            r_en = m_faulted ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 299) != 0);
            drive(r_en, r_al, r_wt);
        end

        @(negedge clk);
        #1;
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
